// File: rtl/sonar_pkg.sv
// Shared types for the sonar transmit path.
// Channel count, delay width, steering delay type and FSM states.
package sonar_pkg;

  localparam int NUM_CH  = 4;
  localparam int DELAY_W = 16;

  typedef logic [DELAY_W-1:0] steer_delay_t;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    LISTEN
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_channel_pulser.sv
// One transmit channel: delay countdown then a square-wave tone burst.
// Optional differential leg under SONAR_TX_DIFF_EN.
module tx_channel_pulser
  import sonar_pkg::*;
#(
  parameter int HALF_PERIOD  = 1250,
  parameter int BURST_CYCLES = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  steer_delay_t delay_i,
  input  logic         start_i,
  input  logic         fire_i,
  input  logic         clr_i,
  output logic         tx_o,
`ifdef SONAR_TX_DIFF_EN
  output logic         tx_n_o,
`endif
  output logic         done_o
);

  localparam int HP_W = $clog2(HALF_PERIOD + 1);
  localparam int HC_W = $clog2(2 * BURST_CYCLES + 1);

  steer_delay_t    wait_q, wait_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [HC_W-1:0] hc_q, hc_d;
  logic            span_q, span_d;
  logic            done_q, done_d;
  logic            tx_q, tx_d;

  // Registers describe the cycle on the outputs; _d is the next cycle.
  always_comb begin
    wait_d = wait_q;
    hp_d   = hp_q;
    hc_d   = hc_q;
    span_d = span_q;
    done_d = done_q;
    tx_d   = tx_q;
    if (clr_i) begin
      wait_d = '0;
      hp_d   = '0;
      hc_d   = '0;
      span_d = 1'b0;
      done_d = 1'b0;
      tx_d   = 1'b0;
    end else if (start_i) begin
      wait_d = delay_i;
      hp_d   = '0;
      hc_d   = '0;
      done_d = 1'b0;
      span_d = (delay_i == '0);
      tx_d   = (delay_i == '0);
    end else if (fire_i && !done_q) begin
      if (!span_q) begin
        if (wait_q <= steer_delay_t'(1)) begin
          wait_d = '0;
          span_d = 1'b1;
          tx_d   = 1'b1;
        end else begin
          wait_d = wait_q - steer_delay_t'(1);
        end
      end else if (hp_q == HP_W'(HALF_PERIOD - 1)) begin
        hp_d = '0;
        if (hc_q == HC_W'(2 * BURST_CYCLES - 1)) begin
          span_d = 1'b0;
          done_d = 1'b1;
          tx_d   = 1'b0;
        end else begin
          hc_d = hc_q + HC_W'(1);
          tx_d = hc_q[0];
        end
      end else begin
        hp_d = hp_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
      hp_q   <= '0;
      hc_q   <= '0;
      span_q <= 1'b0;
      done_q <= 1'b0;
      tx_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      hp_q   <= hp_d;
      hc_q   <= hc_d;
      span_q <= span_d;
      done_q <= done_d;
      tx_q   <= tx_d;
    end
  end

`ifdef SONAR_TX_DIFF_EN
  logic tx_n_q, tx_n_d;

  always_comb tx_n_d = span_d & ~tx_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) tx_n_q <= 1'b0;
    else        tx_n_q <= tx_n_d;
  end

  assign tx_n_o = tx_n_q;
`endif

  assign tx_o   = tx_q;
  assign done_o = done_d;

endmodule

// File: rtl/steered_burst_generator.sv
// Steered multi-channel tone-burst transmitter with listen-window hold-off.
// Define SONAR_TX_DIFF_EN to add the complementary tx_n_out drive.
module steered_burst_generator
  import sonar_pkg::*;
#(
  parameter int HALF_PERIOD   = 1250,
  parameter int BURST_CYCLES  = 8,
  parameter int LISTEN_CYCLES = 2000000
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      start_in,
  input  logic                      abort_in,
  input  steer_delay_t [NUM_CH-1:0] steer_delay_in,
  output logic [NUM_CH-1:0]         tx_out,
`ifdef SONAR_TX_DIFF_EN
  output logic [NUM_CH-1:0]         tx_n_out,
`endif
  output logic                      emit_start_out,
  output logic                      burst_done_out,
  output logic                      listen_out,
  output logic                      busy_out
);

  localparam int T_W   = DELAY_W + 1 + $clog2(2 * HALF_PERIOD * BURST_CYCLES + 1);
  localparam int L_W   = $clog2(LISTEN_CYCLES + 1);
  localparam int CNT_W = max_int(T_W, L_W);

  tx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  steer_delay_t [NUM_CH-1:0] d_q, d_d;
  logic emit_q, emit_d;
  logic bdone_q, bdone_d;
  logic listen_q, listen_d;
  logic busy_q, busy_d;

  logic              accept, kill, fire_step, all_done;
  logic [NUM_CH-1:0] done_w;

  assign accept    = (state_q == IDLE) && start_in;
  assign kill      = (state_q != IDLE) && abort_in;
  assign fire_step = (state_q == FIRE) && !abort_in;
  assign all_done  = &done_w;

  // cnt is time t during FIRE and the listen-window position during LISTEN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = FIRE;
          cnt_d   = '0;
          d_d     = steer_delay_in;
        end
      end
      FIRE: begin
        if (abort_in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (all_done) begin
          state_d = LISTEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LISTEN: begin
        if (abort_in || cnt_q == CNT_W'(LISTEN_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    emit_d   = accept;
    bdone_d  = (state_q == FIRE) && (state_d == LISTEN);
    listen_d = (state_d == LISTEN);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      emit_q   <= 1'b0;
      bdone_q  <= 1'b0;
      listen_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      emit_q   <= emit_d;
      bdone_q  <= bdone_d;
      listen_q <= listen_d;
      busy_q   <= busy_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tx_channel_pulser #(
      .HALF_PERIOD  (HALF_PERIOD),
      .BURST_CYCLES (BURST_CYCLES)
    ) u_pulser (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .delay_i (d_d[k]),
      .start_i (accept),
      .fire_i  (fire_step),
      .clr_i   (kill),
      .tx_o    (tx_out[k]),
`ifdef SONAR_TX_DIFF_EN
      .tx_n_o  (tx_n_out[k]),
`endif
      .done_o  (done_w[k])
    );
  end

  assign emit_start_out = emit_q;
  assign burst_done_out = bdone_q;
  assign listen_out     = listen_q;
  assign busy_out       = busy_q;

endmodule
